// File: rtl/bsg_reset_release_seq.sv
// -----------------------------------------------------------------------------
// bsg_reset_release_seq
//
// Brings a chain of downstream reset domains out of reset one at a time, in
// index order, once the upstream wait-after-reset counter reports ready.
// Each released stage must acknowledge that it is up. After the ack, a fixed
// gap of 2^lg_gap_cycles_p cycles is inserted before the next stage is
// released. done_o rises when the last stage acks. If ready_i drops in any
// active state, every stage is put back into reset and the sequence restarts
// from IDLE.
//
// Optional build macro: BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
//   When defined, a stage that does not ack within 2^lg_timeout_p cycles of
//   its release sends the sequencer to a sticky ERROR state. In ERROR, all
//   stage resets are asserted and error_o is set. ERROR is left only through
//   abort (ready_i low) or reset_n_i.
//   When undefined, the sequencer waits for an ack indefinitely and error_o
//   is tied low.
//
// Ports:
//   clk_i            clock, all flops on the rising edge
//   reset_n_i        asynchronous active-low reset
//   ready_i          upstream "reset wait complete" level (registered upstream)
//   stage_ack_i      per-stage "out of reset and operational" acknowledges
//   stage_reset_o    per-stage active-high reset (registered)
//   current_stage_o  index of the stage currently being released or awaited
//   done_o           every stage released and acked (registered)
//   error_o          sticky ack-timeout flag (registered)
// -----------------------------------------------------------------------------
module bsg_reset_release_seq #(
  parameter  int num_stages_p    = 4,
  parameter  int lg_gap_cycles_p = 4,
  parameter  int lg_timeout_p    = 8,
  localparam int StageW          = (num_stages_p > 1) ? $clog2(num_stages_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    ready_i,
  input  logic [num_stages_p-1:0] stage_ack_i,
  output logic [num_stages_p-1:0] stage_reset_o,
  output logic [StageW-1:0]       current_stage_o,
  output logic                    done_o,
  output logic                    error_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    GAP,
    DONE
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
    , ERROR
`endif
  } state_e;

  localparam logic [StageW-1:0] LastStage = StageW'(num_stages_p - 1);

  state_e                    r_state;
  logic [num_stages_p-1:0]   r_stage_reset;
  logic [StageW-1:0]         r_current_stage;
  logic                      r_done;
  logic [lg_gap_cycles_p-1:0] r_gap_cnt;
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
  logic [lg_timeout_p-1:0]   r_timeout_cnt;
  logic                      r_error;
`endif

  logic              w_ack;
  logic [StageW-1:0] w_next_stage;

  // Only the ack of the stage being awaited matters; every other ack bit is
  // ignored, so a stage that comes up early or glitches cannot skip ahead.
  assign w_ack        = stage_ack_i[r_current_stage];
  assign w_next_stage = r_current_stage + 1'b1;

  // Sequencer. Abort (ready_i low outside IDLE) is checked first so that it
  // wins over a same-cycle ack and over a same-cycle timeout. Stage reset bits
  // only ever fall during sequencing. They all rise together on abort, on
  // timeout, or on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state         <= IDLE;
      r_stage_reset   <= '1;
      r_current_stage <= '0;
      r_done          <= 1'b0;
      r_gap_cnt       <= '0;
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
      r_timeout_cnt   <= '0;
      r_error         <= 1'b0;
`endif
    end else if ((r_state != IDLE) && !ready_i) begin
      r_state         <= IDLE;
      r_stage_reset   <= '1;
      r_current_stage <= '0;
      r_done          <= 1'b0;
      r_gap_cnt       <= '0;
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
      r_timeout_cnt   <= '0;
      r_error         <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (ready_i) begin
            r_stage_reset[0] <= 1'b0;
            r_state          <= WAIT_ACK;
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
            r_timeout_cnt    <= '0;
`endif
          end
        end

        WAIT_ACK: begin
          if (w_ack) begin
            if (r_current_stage == LastStage) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end
          end
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
          // An ack in the saturating cycle is handled above, so it wins.
          else if (r_timeout_cnt == '1) begin
            r_state       <= ERROR;
            r_error       <= 1'b1;
            r_stage_reset <= '1;
            r_done        <= 1'b0;
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
          end
`endif
        end

        // The counter is cleared on GAP entry and stops at its all-ones value,
        // so the gap is exactly 2^lg_gap_cycles_p cycles and never wraps.
        GAP: begin
          if (r_gap_cnt == '1) begin
            r_current_stage              <= w_next_stage;
            r_stage_reset[w_next_stage]  <= 1'b0;
            r_state                      <= WAIT_ACK;
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
            r_timeout_cnt                <= '0;
`endif
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        // DONE and ERROR hold until abort or reset.
        default: begin
        end
      endcase
    end
  end

  assign stage_reset_o   = r_stage_reset;
  assign current_stage_o = r_current_stage;
  assign done_o          = r_done;
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
  assign error_o         = r_error;
`else
  assign error_o         = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_reset_release_seq.sv
// -----------------------------------------------------------------------------
// tb_bsg_reset_release_seq
//
// Directed bench for bsg_reset_release_seq at default parameters. A
// cycle-based model tracks how many stages are released. It also keeps the
// cycle stamp at which the next event is due, which is either the end of a
// gap or a timeout. The model is compared against the DUT after every clock.
// Literal expectations taken from the sequence timing pin the model.
// -----------------------------------------------------------------------------
module tb_bsg_reset_release_seq;

  localparam int NS         = 4;
  localparam int LgGap      = 4;
  localparam int LgTo       = 8;
  localparam int GapLen     = 1 << LgGap;
  localparam int TimeoutLen = 1 << LgTo;
`ifdef BSG_RESET_RELEASE_SEQ_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic          clk_i       = 1'b0;
  logic          reset_n_i   = 1'b1;
  logic          ready_i     = 1'b0;
  logic [NS-1:0] stage_ack_i = '0;
  logic [NS-1:0] stage_reset_o;
  logic [1:0]    current_stage_o;
  logic          done_o;
  logic          error_o;

  int total = 0;
  int bad   = 0;

  bsg_reset_release_seq #(
    .num_stages_p   (NS),
    .lg_gap_cycles_p(LgGap),
    .lg_timeout_p   (LgTo)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .ready_i        (ready_i),
    .stage_ack_i    (stage_ack_i),
    .stage_reset_o  (stage_reset_o),
    .current_stage_o(current_stage_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  always #5 clk_i = ~clk_i;

  // Model state. mRel counts released stages, and 0 means idle. While mGap is
  // set, the next release is due when the free-running cycle count reaches
  // mMark. Otherwise mMark holds the cycle at which the current wait began.
  int cyc   = 0;
  int mRel  = 0;
  bit mGap  = 1'b0;
  bit mDone = 1'b0;
  bit mErr  = 1'b0;
  int mMark = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mRel <= 0; mGap <= 1'b0; mDone <= 1'b0; mErr <= 1'b0; mMark <= 0;
    end else if (mRel == 0 && !mErr) begin
      if (ready_i) begin mRel <= 1; mMark <= cyc; end
    end else if (!ready_i) begin
      mRel <= 0; mGap <= 1'b0; mDone <= 1'b0; mErr <= 1'b0;
    end else if (mErr || mDone) begin
      mRel <= mRel;
    end else if (mGap) begin
      if (cyc == mMark) begin mRel <= mRel + 1; mGap <= 1'b0; mMark <= cyc; end
    end else if (stage_ack_i[mRel-1]) begin
      if (mRel == NS) mDone <= 1'b1;
      else begin mGap <= 1'b1; mMark <= cyc + GapLen; end
    end else if (TimeoutEn && (cyc - mMark == TimeoutLen)) begin
      mErr <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic [NS-1:0] ack);
    ready_i     = rdy;
    stage_ack_i = ack;
  endtask

  // One clock, then compare every output against the model on the falling edge.
  task automatic stepCycle();
    logic [NS-1:0] er;
    logic [1:0]    ec;
    @(posedge clk_i);
    @(negedge clk_i);
    for (int k = 0; k < NS; k++) er[k] = mErr || (k >= mRel);
    ec = (mRel == 0) ? 2'd0 : 2'(mRel - 1);
    checkOutput("model_stage_reset", stage_reset_o, er);
    checkOutput("model_current", current_stage_o, ec);
    checkOutput("model_done", done_o, mDone);
    checkOutput("model_error", error_o, mErr);
  endtask

  // Ack stage k on the third edge after its release. For non-final stages,
  // measure the cycles from that ack edge until the next release is visible.
  task automatic runStage(input int k);
    int n;
    applyStimulus(1'b1, '0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, NS'(1) << k);
    stepCycle();
    n = 1;
    applyStimulus(1'b1, '0);
    if (k < NS - 1) begin
      while (stage_reset_o[k+1] && n < 40) begin
        stepCycle();
        n++;
      end
      checkOutput("release_gap", n, GapLen + 1);
    end
  endtask

  initial begin
    int n;
    #1;
    reset_n_i = 1'b0;
    applyStimulus(1'b1, '0);
    repeat (3) stepCycle();
    checkOutput("rst_stage_reset", stage_reset_o, 4'b1111);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_current", current_stage_o, 0);
    checkOutput("rst_error", error_o, 0);

    reset_n_i = 1'b1;
    stepCycle();
    checkOutput("first_release", stage_reset_o, 4'b1110);

    $display("[TB] spurious acks before stage 0");
    applyStimulus(1'b1, 4'b1110);
    repeat (5) stepCycle();
    checkOutput("spurious_hold_reset", stage_reset_o, 4'b1110);
    checkOutput("spurious_hold_current", current_stage_o, 0);

    $display("[TB] full sequence");
    for (int k = 0; k < NS; k++) runStage(k);
    checkOutput("full_done", done_o, 1);
    checkOutput("full_stage_reset", stage_reset_o, 4'b0000);
    checkOutput("full_current", current_stage_o, 3);
    applyStimulus(1'b1, 4'b0000);
    repeat (3) stepCycle();
    checkOutput("done_holds", done_o, 1);

    $display("[TB] abort from DONE");
    applyStimulus(1'b0, '0);
    stepCycle();
    checkOutput("abort_done_reset", stage_reset_o, 4'b1111);
    checkOutput("abort_done_flag", done_o, 0);
    stepCycle();
    applyStimulus(1'b1, '0);
    stepCycle();
    checkOutput("restart_release", stage_reset_o, 4'b1110);

    $display("[TB] mid-gap abort");
    runStage(0);
    applyStimulus(1'b1, '0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, 4'b0010);
    stepCycle();
    applyStimulus(1'b1, '0);
    repeat (4) stepCycle();
    applyStimulus(1'b0, '0);
    stepCycle();
    checkOutput("gap_abort_reset", stage_reset_o, 4'b1111);
    checkOutput("gap_abort_current", current_stage_o, 0);
    applyStimulus(1'b1, '0);
    stepCycle();
    checkOutput("gap_restart_reset", stage_reset_o, 4'b1110);
    checkOutput("gap_restart_current", current_stage_o, 0);

    $display("[TB] abort and last ack in the same cycle");
    for (int k = 0; k < NS - 1; k++) runStage(k);
    stepCycle();
    applyStimulus(1'b0, 4'b1000);
    stepCycle();
    checkOutput("abort_ack_done", done_o, 0);
    checkOutput("abort_ack_reset", stage_reset_o, 4'b1111);
    checkOutput("abort_ack_current", current_stage_o, 0);
    applyStimulus(1'b1, '0);
    stepCycle();

    if (TimeoutEn) begin
      $display("[TB] timeout on stage 2");
      runStage(0);
      runStage(1);
      n = 0;
      while (!error_o && n < 300) begin
        stepCycle();
        n++;
      end
      checkOutput("timeout_cycles", n, TimeoutLen);
      checkOutput("timeout_reset", stage_reset_o, 4'b1111);
      applyStimulus(1'b1, 4'b0100);
      repeat (3) stepCycle();
      checkOutput("error_sticky", error_o, 1);
      applyStimulus(1'b0, '0);
      stepCycle();
      checkOutput("error_abort", error_o, 0);
      applyStimulus(1'b1, '0);
      stepCycle();

      $display("[TB] ack in the saturating cycle");
      runStage(0);
      runStage(1);
      repeat (TimeoutLen - 1) stepCycle();
      applyStimulus(1'b1, 4'b0100);
      stepCycle();
      n = 1;
      applyStimulus(1'b1, '0);
      checkOutput("sat_ack_error", error_o, 0);
      checkOutput("sat_ack_reset", stage_reset_o, 4'b1000);
      while (stage_reset_o[3] && n < 40) begin
        stepCycle();
        n++;
      end
      checkOutput("sat_ack_gap", n, GapLen + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
